// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - round-robin burst arbiter for the shared video/text memory write port
module vga_mem_arbiter #(
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 16,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(16'h2580),
   parameter int                BURST_MAX  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_CPU,
   input  logic              REQ_IO,
   input  logic              REQ_VGA,
   input  logic [ADDR_W-1:0] ADDR_CPU,
   input  logic [ADDR_W-1:0] ADDR_IO,
   input  logic [ADDR_W-1:0] ADDR_VGA,
   input  logic [DATA_W-1:0] DATA_CPU,
   input  logic [DATA_W-1:0] DATA_IO,
   input  logic [DATA_W-1:0] DATA_VGA,
   output logic              ACK_CPU,
   output logic              ACK_IO,
   output logic              ACK_VGA,
   output logic              MW_OUT,
   output logic [ADDR_W-1:0] WADDR_OUT,
   output logic [DATA_W-1:0] WDATA_OUT,
   output logic              ERR,
   output logic [7:0]        DROP_CNT,
   input  logic              ERR_CLR
);

   typedef enum logic [1:0] {
      SRC_CPU  = 2'd0,
      SRC_IO   = 2'd1,
      SRC_VGA  = 2'd2,
      SRC_NONE = 2'd3
   } src_t;

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

   src_t              ptr;
   src_t              last;
   src_t              win;
   logic [3:0]        burst_cnt;
   logic              last_req;
   logic              others_req;
   logic              burst_ok;
   logic              in_range;
   logic              drop;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Winner: extend the running burst if allowed, otherwise round-robin from the pointer
   always_comb begin
      last_req   = 1'b0;
      others_req = 1'b0;
      case (last)
         SRC_CPU: begin last_req = REQ_CPU; others_req = REQ_IO  | REQ_VGA; end
         SRC_IO:  begin last_req = REQ_IO;  others_req = REQ_CPU | REQ_VGA; end
         SRC_VGA: begin last_req = REQ_VGA; others_req = REQ_CPU | REQ_IO;  end
         default: ;
      endcase
      burst_ok = last_req && ((burst_cnt < BURST_LIM) || !others_req);
      win = SRC_NONE;
      if (burst_ok) begin
         win = last;
      end else begin
         case (ptr)
            SRC_CPU: begin
               if (REQ_CPU)      win = SRC_CPU;
               else if (REQ_IO)  win = SRC_IO;
               else if (REQ_VGA) win = SRC_VGA;
            end
            SRC_IO: begin
               if (REQ_IO)       win = SRC_IO;
               else if (REQ_VGA) win = SRC_VGA;
               else if (REQ_CPU) win = SRC_CPU;
            end
            default: begin
               if (REQ_VGA)      win = SRC_VGA;
               else if (REQ_CPU) win = SRC_CPU;
               else if (REQ_IO)  win = SRC_IO;
            end
         endcase
      end
      if (RST) win = SRC_NONE;
   end

   // Route the winner's address and data toward the write port
   always_comb begin
      sel_addr = ADDR_CPU;
      sel_data = DATA_CPU;
      case (win)
         SRC_IO:  begin sel_addr = ADDR_IO;  sel_data = DATA_IO;  end
         SRC_VGA: begin sel_addr = ADDR_VGA; sel_data = DATA_VGA; end
         default: ;
      endcase
   end

   assign in_range = (sel_addr < ADDR_LIMIT);
   assign drop     = (win != SRC_NONE) && !in_range;
   assign ACK_CPU  = (win == SRC_CPU);
   assign ACK_IO   = (win == SRC_IO);
   assign ACK_VGA  = (win == SRC_VGA);

   // Arbitration state: pointer, last grant and burst length
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr       <= SRC_CPU;
         last      <= SRC_NONE;
         burst_cnt <= 4'd0;
      end else if (win == SRC_NONE) begin
         last      <= SRC_NONE;
         burst_cnt <= 4'd0;
      end else begin
         last <= win;
         case (win)
            SRC_CPU: ptr <= SRC_IO;
            SRC_IO:  ptr <= SRC_VGA;
            default: ptr <= SRC_CPU;
         endcase
         if (win != last)
            burst_cnt <= 4'd1;
         else if (burst_cnt < BURST_LIM)
            burst_cnt <= burst_cnt + 4'd1;
      end
   end

   // Registered memory write port; out-of-range writes leave address/data untouched
   always_ff @(posedge CLK) begin
      if (RST) begin
         MW_OUT    <= 1'b0;
         WADDR_OUT <= '0;
         WDATA_OUT <= '0;
      end else begin
         MW_OUT <= (win != SRC_NONE) && in_range;
         if ((win != SRC_NONE) && in_range) begin
            WADDR_OUT <= sel_addr;
            WDATA_OUT <= sel_data;
         end
      end
   end

   // Sticky error flag and saturating drop counter; a clear beats a simultaneous drop
   always_ff @(posedge CLK) begin
      if (RST) begin
         ERR      <= 1'b0;
         DROP_CNT <= 8'd0;
      end else if (ERR_CLR) begin
         ERR      <= 1'b0;
         DROP_CNT <= 8'd0;
      end else if (drop) begin
         ERR <= 1'b1;
         if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - directed and randomized checks of vga_mem_arbiter against a reference model
module tb_vga_mem_arbiter;
   localparam logic [15:0] LIMIT = 16'h2580;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ERR_CLR;
   logic        req  [3];
   logic [15:0] addr [3];
   logic [15:0] data [3];

   wire [2:0]  ack_a, ack_b;
   wire        mw_a, mw_b, err_a, err_b;
   wire [15:0] waddr_a, waddr_b, wdata_a, wdata_b;
   wire [7:0]  drop_a, drop_b;

   int total = 0;
   int bad   = 0;

   // model state, index 0 = BURST_MAX 4 instance, index 1 = BURST_MAX 1 instance
   int          bm      [2] = '{4, 1};
   int          m_ptr   [2];
   int          m_last  [2];
   int          m_cnt   [2];
   int          m_win   [2];
   logic        m_mw    [2];
   logic [15:0] m_waddr [2];
   logic [15:0] m_wdata [2];
   logic        m_err   [2];
   int          m_drop  [2];

   logic [2:0]  s_ack   [2];
   logic        s_mw    [2];
   logic [15:0] s_waddr [2];
   logic [15:0] s_wdata [2];
   logic        s_err   [2];
   logic [7:0]  s_drop  [2];

   int grants [3];

   vga_mem_arbiter #(.BURST_MAX(4)) u_dut_a (
      .CLK(CLK), .RST(RST),
      .REQ_CPU(req[0]), .REQ_IO(req[1]), .REQ_VGA(req[2]),
      .ADDR_CPU(addr[0]), .ADDR_IO(addr[1]), .ADDR_VGA(addr[2]),
      .DATA_CPU(data[0]), .DATA_IO(data[1]), .DATA_VGA(data[2]),
      .ACK_CPU(ack_a[0]), .ACK_IO(ack_a[1]), .ACK_VGA(ack_a[2]),
      .MW_OUT(mw_a), .WADDR_OUT(waddr_a), .WDATA_OUT(wdata_a),
      .ERR(err_a), .DROP_CNT(drop_a), .ERR_CLR(ERR_CLR)
   );

   vga_mem_arbiter #(.BURST_MAX(1)) u_dut_b (
      .CLK(CLK), .RST(RST),
      .REQ_CPU(req[0]), .REQ_IO(req[1]), .REQ_VGA(req[2]),
      .ADDR_CPU(addr[0]), .ADDR_IO(addr[1]), .ADDR_VGA(addr[2]),
      .DATA_CPU(data[0]), .DATA_IO(data[1]), .DATA_VGA(data[2]),
      .ACK_CPU(ack_b[0]), .ACK_IO(ack_b[1]), .ACK_VGA(ack_b[2]),
      .MW_OUT(mw_b), .WADDR_OUT(waddr_b), .WDATA_OUT(wdata_b),
      .ERR(err_b), .DROP_CNT(drop_b), .ERR_CLR(ERR_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(int k);
      int others;
      if (RST) return -1;
      if (m_last[k] >= 0 && req[m_last[k]]) begin
         others = 0;
         for (int i = 0; i < 3; i++) if (i != m_last[k] && req[i]) others++;
         if (m_cnt[k] < bm[k] || others == 0) return m_last[k];
      end
      for (int j = 0; j < 3; j++) if (req[(m_ptr[k] + j) % 3]) return (m_ptr[k] + j) % 3;
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_ptr[k] = 0; m_last[k] = -1; m_cnt[k] = 0; m_win[k] = -1;
      m_mw[k] = 1'b0; m_waddr[k] = 16'h0; m_wdata[k] = 16'h0;
      m_err[k] = 1'b0; m_drop[k] = 0;
   endtask

   task automatic model_step(input int k);
      int w;
      if (RST) begin
         model_reset(k);
         return;
      end
      w = m_win[k];
      if (w < 0) begin
         m_mw[k] = 1'b0; m_cnt[k] = 0; m_last[k] = -1;
      end else begin
         m_mw[k] = (addr[w] < LIMIT);
         if (m_mw[k]) begin m_waddr[k] = addr[w]; m_wdata[k] = data[w]; end
         m_cnt[k]  = (w == m_last[k]) ? ((m_cnt[k] + 1 > bm[k]) ? bm[k] : m_cnt[k] + 1) : 1;
         m_last[k] = w;
         m_ptr[k]  = (w + 1) % 3;
      end
      if (ERR_CLR) begin
         m_err[k] = 1'b0; m_drop[k] = 0;
      end else if (w >= 0 && addr[w] >= LIMIT) begin
         m_err[k] = 1'b1;
         if (m_drop[k] < 255) m_drop[k]++;
      end
   endtask

   // one clock: sample and compare at negedge, advance the model at posedge
   task automatic cycle();
      string p;
      @(negedge CLK);
      s_ack[0] = ack_a; s_mw[0] = mw_a; s_waddr[0] = waddr_a; s_wdata[0] = wdata_a; s_err[0] = err_a; s_drop[0] = drop_a;
      s_ack[1] = ack_b; s_mw[1] = mw_b; s_waddr[1] = waddr_b; s_wdata[1] = wdata_b; s_err[1] = err_b; s_drop[1] = drop_b;
      for (int k = 0; k < 2; k++) begin
         p = (k == 0) ? "a" : "b";
         m_win[k] = pick(k);
         check_val({p, "_ack"},   32'(s_ack[k]),   (m_win[k] < 0) ? 32'h0 : 32'(1 << m_win[k]));
         check_val({p, "_mw"},    32'(s_mw[k]),    32'(m_mw[k]));
         check_val({p, "_waddr"}, 32'(s_waddr[k]), 32'(m_waddr[k]));
         check_val({p, "_wdata"}, 32'(s_wdata[k]), 32'(m_wdata[k]));
         check_val({p, "_err"},   32'(s_err[k]),   32'(m_err[k]));
         check_val({p, "_drop"},  32'(s_drop[k]),  32'(m_drop[k]));
      end
      @(posedge CLK);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
   endtask

   task automatic new_word(input int i);
      case ($urandom_range(0, 9))
         0:       addr[i] = LIMIT;
         1:       addr[i] = LIMIT - 16'd1;
         2, 3:    addr[i] = 16'($urandom_range(32'h2580, 32'hFFFF));
         default: addr[i] = 16'($urandom_range(0, 32'h257F));
      endcase
      data[i] = 16'($urandom);
   endtask

   task automatic all_req(input logic v);
      for (int i = 0; i < 3; i++) begin
         req[i] = v; addr[i] = 16'(16 * i + 16'h0100); data[i] = 16'(16'hA000 + i);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; cycle(); RST = 1'b0;
   endtask

   localparam logic [2:0] BURST_SEQ [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};

   initial begin
      RST = 1'b1; ERR_CLR = 1'b0;
      all_req(1'b1);
      @(posedge CLK);
      for (int k = 0; k < 2; k++) model_reset(k);
      #1;

      // reset with everyone requesting, then CPU first
      cycle(); cycle();
      check_val("rst_ack_a", 32'(s_ack[0]), 32'h0);
      check_val("rst_mw_a",  32'(s_mw[0]),  32'h0);
      check_val("rst_drop_a", 32'(s_drop[0]), 32'h0);
      RST = 1'b0;
      cycle();
      check_val("first_ack_cpu_a", 32'(s_ack[0]), 32'h1);
      check_val("first_ack_cpu_b", 32'(s_ack[1]), 32'h1);

      // single IO write and its one-cycle latency
      all_req(1'b0);
      cycle(); cycle();
      req[1] = 1'b1; addr[1] = 16'h0010; data[1] = 16'h0041;
      cycle();
      check_val("io_ack", 32'(s_ack[0]), 32'h2);
      req[1] = 1'b0;
      cycle();
      check_val("io_mw",    32'(s_mw[0]),    32'h1);
      check_val("io_waddr", 32'(s_waddr[0]), 32'h0010);
      check_val("io_wdata", 32'(s_wdata[0]), 32'h0041);
      cycle();
      check_val("io_mw_off", 32'(s_mw[0]), 32'h0);

      // fairness with BURST_MAX 1
      do_reset();
      all_req(1'b1);
      grants = '{0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         cycle();
         check_val("fair_order", 32'(s_ack[1]), 32'(1 << (i % 3)));
         for (int j = 0; j < 3; j++) if (s_ack[1][j]) grants[j]++;
      end
      for (int j = 0; j < 3; j++) check_val("fair_count", 32'(grants[j]), 32'd4);

      // burst of 4 on VGA interrupted by a one-word CPU request
      all_req(1'b0);
      do_reset();
      req[2] = 1'b1; addr[2] = 16'h0100; data[2] = 16'h1234;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) begin req[0] = 1'b1; addr[0] = 16'h0200; data[0] = 16'h5678; end
         if (i == 5) req[0] = 1'b0;
         cycle();
         check_val("burst_seq", 32'(s_ack[0]), 32'(BURST_SEQ[i]));
      end
      req[2] = 1'b0;
      cycle();

      // out-of-range drops, saturation, clear, clear-wins and in-range boundary
      req[0] = 1'b1; addr[0] = 16'h2580; data[0] = 16'hBEEF;
      cycle();
      check_val("oor_ack", 32'(s_ack[0]), 32'h1);
      req[0] = 1'b0;
      cycle();
      check_val("oor_mw",   32'(s_mw[0]),   32'h0);
      check_val("oor_err",  32'(s_err[0]),  32'h1);
      check_val("oor_drop", 32'(s_drop[0]), 32'h1);
      req[0] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         addr[0] = 16'($urandom_range(32'h2580, 32'hFFFF));
         cycle();
      end
      req[0] = 1'b0;
      cycle();
      check_val("sat_drop", 32'(s_drop[0]), 32'd255);
      ERR_CLR = 1'b1;
      cycle();
      ERR_CLR = 1'b0;
      cycle();
      check_val("clr_err",  32'(s_err[0]),  32'h0);
      check_val("clr_drop", 32'(s_drop[0]), 32'h0);
      req[0] = 1'b1; addr[0] = 16'hFFFF; ERR_CLR = 1'b1;
      cycle();
      req[0] = 1'b0; ERR_CLR = 1'b0;
      cycle();
      check_val("clrwin_err",  32'(s_err[0]),  32'h0);
      check_val("clrwin_drop", 32'(s_drop[0]), 32'h0);
      req[0] = 1'b1; addr[0] = 16'h257F; data[0] = 16'hCAFE;
      cycle();
      req[0] = 1'b0;
      cycle();
      check_val("edge_mw",    32'(s_mw[0]),    32'h1);
      check_val("edge_waddr", 32'(s_waddr[0]), 32'h257F);

      // reset in the third VGA burst cycle
      req[2] = 1'b1; addr[2] = 16'h0300; data[2] = 16'h0F0F;
      cycle(); cycle();
      RST = 1'b1;
      cycle();
      check_val("midrst_ack", 32'(s_ack[0]), 32'h0);
      RST = 1'b0;
      all_req(1'b1);
      cycle();
      check_val("midrst_mw",  32'(s_mw[0]),  32'h0);
      check_val("midrst_ptr", 32'(s_ack[0]), 32'h1);
      all_req(1'b0);
      cycle();

      // randomized traffic following the request/ack handshake
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (req[i] && m_win[0] == i) begin
               if ($urandom_range(0, 1) == 1) new_word(i);
               else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               new_word(i);
            end
         end
         ERR_CLR = ($urandom_range(0, 19) == 0);
         RST     = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
